// File: rtl/scr1_accel_vmac.sv
// Vector multiply / dot-product accelerator, a polled slave on the SCR1 dmem bus.
// One element pair of A and B is multiplied per cycle into packed products or a 32-bit accumulator.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_accel_vmac_pkg;
    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [2:0] idx;
        logic [1:0] sub;
        logic [3:0] be;
    } vmac_req_t;
endpackage

module scr1_accel_vmac
    import scr1_accel_vmac_pkg::*;
#(
    parameter int ELEM_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          dmem_req_ack,
    input  logic                          dmem_req,
    input  type_scr1_mem_cmd_e            dmem_cmd,
    input  type_scr1_mem_width_e          dmem_width,
    input  logic [`SCR1_DMEM_AWIDTH-1:0]  dmem_addr,
    input  logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_wdata,
    output logic [`SCR1_DMEM_DWIDTH-1:0]  dmem_rdata,
    output type_scr1_mem_resp_e           dmem_resp
);

    localparam int N_ELEM = 32 / ELEM_W;
    localparam int PW     = 2 * ELEM_W;
    localparam int EL_W   = $clog2(N_ELEM);
    localparam logic [2:0] IDX_LAST = 3'(N_ELEM - 1);

    vmac_req_t req;
    logic      unused_addr;

    logic [31:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [63:0]  res_q, res_d;
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic         mode_q, mode_d, sgn_q, sgn_d, keep_q, keep_d;
    logic [2:0]   idx_q, idx_d;
    logic [15:0]  cnt_q, cnt_d;
    logic [31:0]  rdata_q, rdata_d;
    type_scr1_mem_resp_e resp_q, resp_d;

    logic [EL_W-1:0]   el;
    logic [ELEM_W-1:0] ea, eb;
    logic [PW-1:0]     opa, opb, prod;
    logic [31:0]       prod_ext;
    logic [31:0]       rsel;
    logic              err_set, ctrl_wr;

    assign dmem_req_ack = 1'b1;
    assign unused_addr  = ^dmem_addr[31:5];

    always_comb begin
        req.rd  = dmem_req & (dmem_cmd == SCR1_MEM_CMD_RD);
        req.wr  = dmem_req & (dmem_cmd == SCR1_MEM_CMD_WR);
        req.idx = dmem_addr[4:2];
        req.sub = dmem_addr[1:0];
        case (dmem_width)
            SCR1_MEM_WIDTH_BYTE:  req.be = 4'b0001 << dmem_addr[1:0];
            SCR1_MEM_WIDTH_HWORD: req.be = dmem_addr[1] ? 4'b1100 : 4'b0011;
            default:              req.be = 4'b1111;
        endcase
    end

    // Write data is lane-aligned: byte k of wdata lands in byte k of the register.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // Sign-extending to PW bits makes the low PW bits of the product exact for both signednesses.
    assign el   = idx_q[EL_W-1:0];
    assign ea   = a_q[int'(el)*ELEM_W +: ELEM_W];
    assign eb   = b_q[int'(el)*ELEM_W +: ELEM_W];
    assign opa  = {{ELEM_W{sgn_q & ea[ELEM_W-1]}}, ea};
    assign opb  = {{ELEM_W{sgn_q & eb[ELEM_W-1]}}, eb};
    assign prod = opa * opb;

    generate
        if (PW < 32) begin : g_ext
            assign prod_ext = {{(32-PW){sgn_q & prod[PW-1]}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

    assign ctrl_wr = req.wr & (req.idx == 3'd0) & req.be[0];

    always_comb begin
        a_d = a_q;  b_d = b_q;  acc_d = acc_q;  res_d = res_q;
        busy_d = busy_q;  done_d = done_q;
        mode_d = mode_q;  sgn_d = sgn_q;  keep_d = keep_q;
        idx_d = idx_q;  cnt_d = cnt_q;
        err_set = 1'b0;

        if (busy_q) begin
            if (mode_q) acc_d = acc_q + prod_ext;
            else        res_d[int'(el)*PW +: PW] = prod;
            idx_d = idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                cnt_d  = cnt_q + 16'd1;
            end
        end

        if (req.wr) begin
            case (req.idx)
                3'd0: if (ctrl_wr && dmem_wdata[0]) begin
                    if (busy_q) err_set = 1'b1;
                    else begin
                        mode_d = dmem_wdata[1];
                        sgn_d  = dmem_wdata[2];
                        keep_d = dmem_wdata[3];
                        done_d = 1'b0;
                        busy_d = 1'b1;
                        idx_d  = 3'd0;
                        if (!dmem_wdata[1])     res_d = '0;
                        else if (!dmem_wdata[3]) acc_d = '0;
                    end
                end
                3'd2: if (busy_q) err_set = 1'b1; else a_d = merge(a_q, dmem_wdata, req.be);
                3'd3: if (busy_q) err_set = 1'b1; else b_d = merge(b_q, dmem_wdata, req.be);
                default: ;
            endcase
        end

        // A same-cycle violation outranks the clear.
        err_d = (err_q & ~(ctrl_wr & dmem_wdata[4])) | err_set;
    end

    always_comb begin
        case (req.idx)
            3'd0:    rsel = {done_q, err_q, 26'b0, keep_q, sgn_q, mode_q, busy_q};
            3'd1:    rsel = {cnt_q, 13'b0, idx_q};
            3'd2:    rsel = a_q;
            3'd3:    rsel = b_q;
            3'd4:    rsel = acc_q;
            3'd5:    rsel = res_q[31:0];
            3'd6:    rsel = res_q[63:32];
            default: rsel = '0;
        endcase
        rdata_d = req.rd ? (rsel >> {req.sub, 3'b000}) : '0;
        if (!dmem_req)           resp_d = SCR1_MEM_RESP_NOTRDY;
        else if (req.idx == 3'd7) resp_d = SCR1_MEM_RESP_RDY_ER;
        else                     resp_d = SCR1_MEM_RESP_RDY_OK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;  b_q <= '0;  acc_q <= '0;  res_q <= '0;
            busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
            mode_q <= 1'b0;  sgn_q <= 1'b0;  keep_q <= 1'b0;
            idx_q <= '0;  cnt_q <= '0;
            rdata_q <= '0;  resp_q <= SCR1_MEM_RESP_NOTRDY;
        end else begin
            a_q <= a_d;  b_q <= b_d;  acc_q <= acc_d;  res_q <= res_d;
            busy_q <= busy_d;  done_q <= done_d;  err_q <= err_d;
            mode_q <= mode_d;  sgn_q <= sgn_d;  keep_q <= keep_d;
            idx_q <= idx_d;  cnt_q <= cnt_d;
            rdata_q <= rdata_d;  resp_q <= resp_d;
        end
    end

    assign dmem_rdata = rdata_q;
    assign dmem_resp  = resp_q;

endmodule

// File: tb/tb_scr1_accel_vmac.sv
// Bench for scr1_accel_vmac: ELEM_W=8 and ELEM_W=16 instances on a shared bus,
// directed register-map cases plus random operations against an arithmetic reference model.

module tb_scr1_accel_vmac;
    import scr1_accel_vmac_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]           req;
    type_scr1_mem_cmd_e   cmd;
    type_scr1_mem_width_e wid;
    logic [31:0]          addr, wdata;
    logic                 ack8, ack16;
    logic [31:0]          rdata8, rdata16;
    type_scr1_mem_resp_e  resp8, resp16;

    scr1_accel_vmac #(.ELEM_W(8)) u_e8 (
        .clk(clk), .rst_n(rst_n), .dmem_req_ack(ack8), .dmem_req(req[0]),
        .dmem_cmd(cmd), .dmem_width(wid), .dmem_addr(addr), .dmem_wdata(wdata),
        .dmem_rdata(rdata8), .dmem_resp(resp8));

    scr1_accel_vmac #(.ELEM_W(16)) u_e16 (
        .clk(clk), .rst_n(rst_n), .dmem_req_ack(ack16), .dmem_req(req[1]),
        .dmem_cmd(cmd), .dmem_width(wid), .dmem_addr(addr), .dmem_wdata(wdata),
        .dmem_rdata(rdata16), .dmem_resp(resp16));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference state: accumulator, packed products and op counter per instance.
    logic [31:0] m_acc [2];
    logic [63:0] m_res [2];
    logic [15:0] m_cnt [2];

    function automatic longint sval(input longint u, input int e, input bit s);
        return (s && u >= (longint'(1) << (e - 1))) ? u - (longint'(1) << e) : u;
    endfunction

    task automatic m_op(input int w, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ctrl);
        int     e, n;
        longint mask, ua, ub, p;
        e = (w == 0) ? 8 : 16;
        n = 32 / e;
        mask = (longint'(1) << e) - 1;
        if (!ctrl[1])      m_res[w] = '0;
        else if (!ctrl[3]) m_acc[w] = '0;
        for (int i = 0; i < n; i++) begin
            ua = (longint'(a) >> (i * e)) & mask;
            ub = (longint'(b) >> (i * e)) & mask;
            p  = sval(ua, e, ctrl[2]) * sval(ub, e, ctrl[2]);
            if (!ctrl[1])
                m_res[w] = m_res[w] | ((64'(p) & ((64'd1 << (2 * e)) - 1)) << (i * 2 * e));
            else
                m_acc[w] = m_acc[w] + 32'(p);
        end
        m_cnt[w] = m_cnt[w] + 16'd1;
    endtask

    task automatic m_reset();
        for (int w = 0; w < 2; w++) begin
            m_acc[w] = '0; m_res[w] = '0; m_cnt[w] = '0;
        end
    endtask

    // Called at a negedge; returns at the next negedge with the response, so calls chain back-to-back.
    task automatic xfer(input int w, input logic wr, input type_scr1_mem_width_e wd,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic [1:0] rs);
        req   = (w == 0) ? 2'b01 : 2'b10;
        cmd   = wr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        wid   = wd;
        addr  = a;
        wdata = d;
        @(negedge clk);
        rd  = (w == 0) ? rdata8 : rdata16;
        rs  = (w == 0) ? resp8 : resp16;
        req = 2'b00;
    endtask

    task automatic wr32(input int w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd; logic [1:0] rs;
        xfer(w, 1'b1, SCR1_MEM_WIDTH_WORD, a, d, rd, rs);
        chk("wr_resp", {30'b0, rs}, {30'b0, SCR1_MEM_RESP_RDY_OK});
    endtask

    task automatic rd32(input int w, input logic [31:0] a, output logic [31:0] d);
        logic [1:0] rs;
        xfer(w, 1'b0, SCR1_MEM_WIDTH_WORD, a, 32'h0, d, rs);
        chk("rd_resp", {30'b0, rs}, {30'b0, SCR1_MEM_RESP_RDY_OK});
    endtask

    task automatic poll(input int w, output int nb, output logic [31:0] c);
        logic [1:0] rs;
        nb = 0;
        c  = '0;
        for (int k = 0; k < 40; k++) begin
            xfer(w, 1'b0, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0, c, rs);
            if (!c[0]) break;
            nb++;
        end
        chk("poll_idle", {31'b0, c[0]}, 32'h0);
    endtask

    task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] ctrl, output logic [31:0] acc,
                          output logic [31:0] r0, output logic [31:0] r1, output logic [31:0] cnt);
        int nb; logic [31:0] c;
        wr32(w, 32'h08, a);
        wr32(w, 32'h0C, b);
        wr32(w, 32'h00, {27'b0, ctrl});
        poll(w, nb, c);
        chk("busy_cycles", nb, (w == 0) ? 32'd4 : 32'd2);
        chk("done", {31'b0, c[31]}, 32'h1);
        m_op(w, a, b, ctrl);
        rd32(w, 32'h10, acc);  chk("acc",  acc, m_acc[w]);
        rd32(w, 32'h14, r0);   chk("res0", r0, m_res[w][31:0]);
        rd32(w, 32'h18, r1);   chk("res1", r1, m_res[w][63:32]);
        rd32(w, 32'h04, cnt);  chk("count", cnt, {m_cnt[w], 13'b0, (w == 0) ? 3'd4 : 3'd2});
    endtask

    initial begin
        logic [31:0] acc, r0, r1, cnt, d, c;
        logic [1:0]  rs;
        int          nb;

        rst_n = 1'b0; req = 2'b00; cmd = SCR1_MEM_CMD_RD; wid = SCR1_MEM_WIDTH_WORD;
        addr = '0; wdata = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_resp", {30'b0, resp8}, {30'b0, SCR1_MEM_RESP_NOTRDY});
        chk("rst_rdata", rdata8, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        rd32(0, 32'h00, d); chk("rst_ctrl", d, 32'h0);
        rd32(0, 32'h04, d); chk("rst_count", d, 32'h0);
        rd32(1, 32'h10, d); chk("rst_acc16", d, 32'h0);

        // ELEM_W=8 directed cases
        run_op(0, 32'h04030201, 32'h08070605, 5'h01, acc, r0, r1, cnt);
        chk("e8_res0", r0, 32'h000C0005);
        chk("e8_res1", r1, 32'h00200015);
        chk("e8_count", cnt, 32'h00010004);
        run_op(0, 32'h04030201, 32'h08070605, 5'h03, acc, r0, r1, cnt);
        chk("e8_dot", acc, 32'h00000046);
        run_op(0, 32'h04030201, 32'h08070605, 5'h0B, acc, r0, r1, cnt);
        chk("e8_dot_keep", acc, 32'h0000008C);
        chk("e8_opcnt3", cnt, 32'h00030004);
        run_op(0, 32'h000000FF, 32'h00000002, 5'h07, acc, r0, r1, cnt);
        chk("e8_sdot", acc, 32'hFFFFFFFE);
        run_op(0, 32'h000000FF, 32'h00000002, 5'h05, acc, r0, r1, cnt);
        chk("e8_sres0", r0, 32'h0000FFFE);

        // Go and A-write while busy are rejected and flag err
        wr32(0, 32'h08, 32'h04030201);
        wr32(0, 32'h0C, 32'h08070605);
        wr32(0, 32'h00, 32'h3);
        wr32(0, 32'h00, 32'h3);
        wr32(0, 32'h08, 32'hDEADBEEF);
        poll(0, nb, c);
        m_op(0, 32'h04030201, 32'h08070605, 5'h03);
        chk("viol_err", {31'b0, c[30]}, 32'h1);
        rd32(0, 32'h08, d);  chk("viol_a", d, 32'h04030201);
        rd32(0, 32'h10, d);  chk("viol_acc", d, 32'h00000046);
        rd32(0, 32'h04, d);  chk("viol_count", d, {m_cnt[0], 13'b0, 3'd4});
        wr32(0, 32'h00, 32'h10);
        rd32(0, 32'h00, d);  chk("err_clr", d, 32'h80000002);

        // Bus corner cases
        xfer(0, 1'b0, SCR1_MEM_WIDTH_WORD, 32'h1C, 32'h0, d, rs);
        chk("unmap_resp", {30'b0, rs}, {30'b0, SCR1_MEM_RESP_RDY_ER});
        chk("unmap_rdata", d, 32'h0);
        xfer(0, 1'b1, SCR1_MEM_WIDTH_WORD, 32'h1C, 32'h12345678, d, rs);
        chk("unmap_wr_resp", {30'b0, rs}, {30'b0, SCR1_MEM_RESP_RDY_ER});
        xfer(0, 1'b0, SCR1_MEM_WIDTH_BYTE, 32'h0A, 32'h0, d, rs);
        chk("byte_rd", {24'b0, d[7:0]}, 32'h03);
        xfer(0, 1'b1, SCR1_MEM_WIDTH_BYTE, 32'h09, {4{8'hAA}}, d, rs);
        rd32(0, 32'h08, d);  chk("byte_wr", d, 32'h0403AA01);
        xfer(0, 1'b1, SCR1_MEM_WIDTH_HWORD, 32'h0E, {2{16'h5A5A}}, d, rs);
        rd32(0, 32'h0C, d);  chk("hword_wr", d, 32'h5A5A0605);
        wr32(0, 32'h10, 32'hFFFFFFFF);
        rd32(0, 32'h10, d);  chk("acc_ro", d, 32'h00000046);

        // Reset in the middle of an operation
        wr32(0, 32'h00, 32'h3);
        req = 2'b01; cmd = SCR1_MEM_CMD_RD; wid = SCR1_MEM_WIDTH_WORD; addr = 32'h0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_resp", {30'b0, resp8}, {30'b0, SCR1_MEM_RESP_NOTRDY});
        chk("midrst_rdata", rdata8, 32'h0);
        req = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        rd32(0, 32'h00, d);  chk("midrst_ctrl", d, 32'h0);
        rd32(0, 32'h10, d);  chk("midrst_acc", d, 32'h0);

        // ELEM_W=16 directed cases
        run_op(1, 32'h00030002, 32'h00050004, 5'h01, acc, r0, r1, cnt);
        chk("e16_res0", r0, 32'h00000008);
        chk("e16_res1", r1, 32'h0000000F);
        run_op(1, 32'h00030002, 32'h00050004, 5'h03, acc, r0, r1, cnt);
        chk("e16_dot", acc, 32'h00000017);

        // Random operations on both widths
        for (int w = 0; w < 2; w++) begin
            for (int it = 0; it < 12; it++) begin
                logic [4:0] ctl;
                ctl = {1'b0, 3'($urandom_range(0, 7)), 1'b1};
                run_op(w, $urandom, $urandom, ctl, acc, r0, r1, cnt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
